// File: rtl/unidade_entrada.sv
// Input-device controller for the IN instruction: stalls the pipeline, debounces the
// confirm button and delivers the latched switch word for one writeback cycle.
module unidade_entrada #(
    parameter int LARGURA_CHAVES  = 16,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int EXTENDE_SINAL   = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      entradaReq,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botaoConfirma,
    output logic [31:0]               dadosEntrada,
    output logic                      pausa,
    output logic                      entradaPronta,
    output logic [2:0]                estadoEntrada
);

    localparam int LARGURA_CONT = $clog2(DEBOUNCE_CICLOS);
    localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
    localparam int PREENCHIMENTO = 32 - LARGURA_CHAVES;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_SOLTAR = 3'd1,
        ESPERA_APERTO = 3'd2,
        ENTREGA       = 3'd3
    } estado_t;

    estado_t                   estado;
    estado_t                   estadoProx;
    logic                      botaoMeta;
    logic                      botaoSinc;
    logic [LARGURA_CHAVES-1:0] chavesMeta;
    logic [LARGURA_CHAVES-1:0] chavesSinc;
    logic [LARGURA_CONT-1:0]   contador;
    logic                      nivelOk;
    logic                      capturar;
    logic [31:0]               chavesExt;

    always_ff @(posedge clock) begin
        if (reset) begin
            botaoMeta  <= 1'b0;
            botaoSinc  <= 1'b0;
            chavesMeta <= '0;
            chavesSinc <= '0;
        end else begin
            botaoMeta  <= botaoConfirma;
            botaoSinc  <= botaoMeta;
            chavesMeta <= chaves;
            chavesSinc <= chavesMeta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estadoProx;
        end
    end

    // Abort on a dropped request takes priority over an accepting debounce sample.
    always_comb begin
        estadoProx = estado;
        nivelOk    = 1'b0;
        capturar   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (entradaReq) estadoProx = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                nivelOk = ~botaoSinc;
                if (!entradaReq) estadoProx = OCIOSO;
                else if (nivelOk && contador == CONT_MAX) estadoProx = ESPERA_APERTO;
            end
            ESPERA_APERTO: begin
                nivelOk = botaoSinc;
                if (!entradaReq) begin
                    estadoProx = OCIOSO;
                end else if (nivelOk && contador == CONT_MAX) begin
                    estadoProx = ENTREGA;
                    capturar   = 1'b1;
                end
            end
            ENTREGA: estadoProx = OCIOSO;
            default: estadoProx = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || estadoProx != estado || !nivelOk) begin
            contador <= '0;
        end else if (contador != CONT_MAX) begin
            contador <= contador + 1'b1;
        end
    end

    always_comb begin
        if (EXTENDE_SINAL != 0) begin
            chavesExt = {{PREENCHIMENTO{chavesSinc[LARGURA_CHAVES-1]}}, chavesSinc};
        end else begin
            chavesExt = {{PREENCHIMENTO{1'b0}}, chavesSinc};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dadosEntrada <= '0;
        end else if (capturar) begin
            dadosEntrada <= chavesExt;
        end
    end

    always_comb begin
        pausa         = 1'b0;
        entradaPronta = 1'b0;
        estadoEntrada = estado;
        case (estado)
            ESPERA_SOLTAR: pausa = 1'b1;
            ESPERA_APERTO: pausa = 1'b1;
            ENTREGA:       entradaPronta = 1'b1;
            default:       pausa = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_unidade_entrada.sv
// Directed bench for unidade_entrada with a short debounce; a zero-extending and a
// sign-extending instance share all inputs.
module tb_unidade_entrada;

    logic        clock = 1'b0;
    logic        reset;
    logic        entradaReq;
    logic [15:0] chaves;
    logic        botaoConfirma;
    logic [31:0] dadosZ, dadosS;
    logic        pausaZ, pausaS;
    logic        prontaZ, prontaS;
    logic [2:0]  estadoZ, estadoS;

    int total = 0;
    int passou = 0;
    int contaPronta = 0;
    int base;

    always #5 clock = ~clock;

    unidade_entrada #(.LARGURA_CHAVES(16), .DEBOUNCE_CICLOS(4), .EXTENDE_SINAL(0)) dutZ (
        .clock(clock), .reset(reset), .entradaReq(entradaReq), .chaves(chaves),
        .botaoConfirma(botaoConfirma), .dadosEntrada(dadosZ), .pausa(pausaZ),
        .entradaPronta(prontaZ), .estadoEntrada(estadoZ)
    );

    unidade_entrada #(.LARGURA_CHAVES(16), .DEBOUNCE_CICLOS(4), .EXTENDE_SINAL(1)) dutS (
        .clock(clock), .reset(reset), .entradaReq(entradaReq), .chaves(chaves),
        .botaoConfirma(botaoConfirma), .dadosEntrada(dadosS), .pausa(pausaS),
        .entradaPronta(prontaS), .estadoEntrada(estadoS)
    );

    always @(negedge clock) if (prontaZ) contaPronta++;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs === esp) passou++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, esp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic esperaEstado(input logic [2:0] alvo, input string tag);
        for (int i = 0; i < 60 && estadoZ != alvo; i++) tick();
        confere(tag, 32'(estadoZ), 32'(alvo));
    endtask

    task automatic esperaPronta(input string tag);
        for (int i = 0; i < 60 && !prontaZ; i++) tick();
        confere(tag, 32'(prontaZ), 32'd1);
    endtask

    int padrao [19] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int esp;

    initial begin
        reset = 1'b1; entradaReq = 1'b0; chaves = '0; botaoConfirma = 1'b0;
        repeat (3) tick();
        confere("rst_estado", 32'(estadoZ), 32'd0);
        confere("rst_pausa", 32'(pausaZ), 32'd0);
        confere("rst_pronta", 32'(prontaZ), 32'd0);
        confere("rst_dados", dadosZ, 32'd0);
        reset = 1'b0;
        tick();
        confere("ocioso_pausa", 32'(pausaZ), 32'd0);

        // 1: nominal capture; press from cycle 10 is accepted at cycle 16
        base = contaPronta;
        entradaReq = 1'b1; chaves = 16'h00A5;
        for (int c = 1; c <= 17; c++) begin
            tick();
            esp = (c < 5) ? 1 : (c < 16) ? 2 : (c == 16) ? 3 : 0;
            confere("t1_estado", 32'(estadoZ), 32'(esp));
            confere("t1_pausa", 32'(pausaZ), (esp == 1 || esp == 2) ? 32'd1 : 32'd0);
            confere("t1_pronta", 32'(prontaZ), (esp == 3) ? 32'd1 : 32'd0);
            if (c == 15) confere("t1_dados_antes", dadosZ, 32'd0);
            if (c == 10) botaoConfirma = 1'b1;
            if (c == 16) entradaReq = 1'b0;
        end
        confere("t1_strobes", 32'(contaPronta - base), 32'd1);
        confere("t1_dados", dadosZ, 32'h000000A5);

        // 2: sign vs zero extension
        chaves = 16'h8001; botaoConfirma = 1'b0; entradaReq = 1'b1;
        esperaEstado(3'd2, "t2_aperto");
        botaoConfirma = 1'b1;
        esperaPronta("t2_pronta");
        confere("t2_dadosZ", dadosZ, 32'h00008001);
        confere("t2_dadosS", dadosS, 32'hFFFF8001);
        entradaReq = 1'b0; botaoConfirma = 1'b0;
        tick();

        // 3: bounce of 1/2/3 cycles rejected, 6-cycle press accepted
        chaves = 16'h1234; entradaReq = 1'b1;
        esperaEstado(3'd2, "t3_aperto");
        base = contaPronta;
        for (int i = 0; i < 19; i++) begin
            botaoConfirma = padrao[i][0];
            tick();
            esp = (i < 14) ? 2 : (i == 14) ? 3 : 0;
            confere("t3_estado", 32'(estadoZ), 32'(esp));
            if (prontaZ) entradaReq = 1'b0;
        end
        confere("t3_strobes", 32'(contaPronta - base), 32'd1);
        confere("t3_dados", dadosZ, 32'h00001234);

        // 4: button already held when the request arrives
        botaoConfirma = 1'b1;
        repeat (5) tick();
        base = contaPronta;
        chaves = 16'h0BEE; entradaReq = 1'b1;
        tick();
        confere("t4_entra", 32'(estadoZ), 32'd1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            confere("t4_segurado", 32'(estadoZ), 32'd1);
        end
        botaoConfirma = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            confere("t4_soltar", 32'(estadoZ), (k < 6) ? 32'd1 : 32'd2);
        end
        botaoConfirma = 1'b1;
        for (int m = 1; m <= 6; m++) begin
            tick();
            confere("t4_apertar", 32'(estadoZ), (m < 6) ? 32'd2 : 32'd3);
            if (m == 6) entradaReq = 1'b0;
        end
        tick();
        confere("t4_strobes", 32'(contaPronta - base), 32'd1);
        confere("t4_dados", dadosZ, 32'h00000BEE);

        // 5A: abort in ESPERA_APERTO
        botaoConfirma = 1'b0; chaves = 16'h7777; entradaReq = 1'b1;
        esperaEstado(3'd2, "t5a_aperto");
        base = contaPronta;
        botaoConfirma = 1'b1; entradaReq = 1'b0;
        tick();
        confere("t5a_estado", 32'(estadoZ), 32'd0);
        confere("t5a_pausa", 32'(pausaZ), 32'd0);
        repeat (6) tick();
        confere("t5a_dados", dadosZ, 32'h00000BEE);
        confere("t5a_strobes", 32'(contaPronta - base), 32'd0);

        // 5B: reset in ESPERA_APERTO with the button pressed
        botaoConfirma = 1'b0; entradaReq = 1'b1;
        esperaEstado(3'd2, "t5b_aperto");
        botaoConfirma = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        confere("t5b_estado", 32'(estadoZ), 32'd0);
        confere("t5b_pausa", 32'(pausaZ), 32'd0);
        confere("t5b_pronta", 32'(prontaZ), 32'd0);
        confere("t5b_dadosZ", dadosZ, 32'd0);
        confere("t5b_dadosS", dadosS, 32'd0);
        reset = 1'b0; entradaReq = 1'b0; botaoConfirma = 1'b0;
        tick();

        // 6: back-to-back IN with the request held through ENTREGA
        base = contaPronta;
        chaves = 16'h0003; entradaReq = 1'b1;
        esperaEstado(3'd2, "t6_aperto1");
        botaoConfirma = 1'b1;
        esperaPronta("t6_pronta1");
        confere("t6_dados1", dadosZ, 32'h00000003);
        chaves = 16'h0004;
        tick();
        confere("t6_ocioso", 32'(estadoZ), 32'd0);
        tick();
        confere("t6_soltar", 32'(estadoZ), 32'd1);
        repeat (4) tick();
        confere("t6_segurado", 32'(estadoZ), 32'd1);
        botaoConfirma = 1'b0;
        esperaEstado(3'd2, "t6_aperto2");
        botaoConfirma = 1'b1;
        esperaPronta("t6_pronta2");
        confere("t6_dados2", dadosZ, 32'h00000004);
        entradaReq = 1'b0; botaoConfirma = 1'b0;
        repeat (2) tick();
        confere("t6_strobes", 32'(contaPronta - base), 32'd2);

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule
